// File: rtl/multi_tick_gen_pkg.sv
// Shared constants, config struct and helpers for the multi-channel tick generator.
package multi_tick_gen_pkg;

    localparam int unsigned DEF_DIV_1HZ = 50_000_000;
    localparam int unsigned DEF_DIV_2HZ = 25_000_000;
    localparam int          CFG_DIV_W   = 32;

    typedef struct packed {
        logic [CFG_DIV_W-1:0] div;
        logic                 pending;
    } ch_cfg_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: up-counter, active/shadow divisor pair and registered tick.
// MULTI_TICK_GEN_SQ_EN adds a square-wave output toggled on every terminal count.
module tick_channel
    import multi_tick_gen_pkg::*;
#(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_1HZ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             pending
`ifdef MULTI_TICK_GEN_SQ_EN
    ,
    output logic             sq
`endif
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] shadow_div;
    logic [CNT_W-1:0] last_cnt;
    logic             at_tc;

    // Divisor 0 behaves as 1, so the terminal count is 0 in both cases.
    always_comb begin
        last_cnt = (active_div == '0) ? '0 : active_div - CNT_W'(1);
    end

    assign at_tc = (cnt == last_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            active_div <= DEF_DIV;
            shadow_div <= DEF_DIV;
            pending    <= 1'b0;
            tick       <= 1'b0;
`ifdef MULTI_TICK_GEN_SQ_EN
            sq         <= 1'b0;
`endif
        end else begin
            if (wr) begin
                shadow_div <= wr_div;
            end
            // A write is only accepted while not pending, so pending <= wr keeps a
            // same-cycle write queued for the next boundary.
            if (restart) begin
                cnt     <= '0;
                tick    <= 1'b0;
                pending <= wr;
                if (pending) begin
                    active_div <= shadow_div;
                end
`ifdef MULTI_TICK_GEN_SQ_EN
                sq      <= 1'b0;
`endif
            end else if (en && at_tc) begin
                cnt     <= '0;
                tick    <= 1'b1;
                pending <= wr;
                if (pending) begin
                    active_div <= shadow_div;
                end
`ifdef MULTI_TICK_GEN_SQ_EN
                sq      <= ~sq;
`endif
            end else begin
                if (en) begin
                    cnt <= cnt + CNT_W'(1);
                end
                tick    <= 1'b0;
                pending <= pending | wr;
            end
        end
    end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: config decode and ready mux over NUM_CH channels.
// Optional square-wave outputs are enabled with MULTI_TICK_GEN_SQ_EN.
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = DEF_DIV_1HZ,
    localparam int         CH_W    = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick
`ifdef MULTI_TICK_GEN_SQ_EN
    ,
    output logic [NUM_CH-1:0] sq
`endif
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;
    logic              accept;

    // Handshake: a write transfers on any edge where cfg_valid && cfg_ready; the
    // master holds cfg_ch/cfg_div stable until then. Out-of-range channels are
    // always ready and the write is silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g] = accept && (cfg_ch == CH_W'(g));

        tick_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (CNT_W'(DEF_DIV))
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .restart (restart),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .tick    (tick[g]),
            .pending (pending[g])
`ifdef MULTI_TICK_GEN_SQ_EN
            ,
            .sq      (sq[g])
`endif
        );
    end

endmodule
